// File: rtl/flipdot_scan_ctrl.sv
// Flipdot frame scanner: walks each dot row-major, fetches its pixel and fires
// a timed coil pulse of matching polarity, followed by a timed settle gap.
module flipdot_scan_ctrl #(
    parameter int COLS      = 28,
    parameter int ROWS      = 14,
    parameter int CW        = 5,
    parameter int RW        = 4,
    parameter int TW        = 16,
    parameter int PULSE_CYC = 1000,
    parameter int GAP_CYC   = 200
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          tick,
    input  logic          start,
    input  logic          abort,
    output logic          rd_en,
    output logic [RW-1:0] rd_row,
    output logic [CW-1:0] rd_col,
    input  logic          rd_data,
    output logic          drv_set,
    output logic          drv_clr,
    output logic          busy,
    output logic          frame_done
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LATCH, S_PULSE, S_GAP} state_t;

    localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_CYC - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYC - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);

    state_t          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            pix_q, pix_d;
    logic            rd_en_q, rd_en_d;
    logic            drv_set_q, drv_set_d;
    logic            drv_clr_q, drv_clr_d;
    logic            busy_q, busy_d;
    logic            frame_done_q, frame_done_d;

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        timer_d      = timer_q;
        pix_d        = pix_q;
        frame_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    row_d   = '0;
                    col_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                pix_d   = rd_data;
                timer_d = '0;
                state_d = S_PULSE;
            end
            S_PULSE: begin
                if (tick) begin
                    if (timer_q == PULSE_LAST) begin
                        timer_d = '0;
                        state_d = S_GAP;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            S_GAP: begin
                if (tick) begin
                    if (timer_q == GAP_LAST) begin
                        timer_d = '0;
                        if (row_q == ROW_LAST && col_q == COL_LAST) begin
                            state_d      = S_IDLE;
                            frame_done_d = 1'b1;
                        end else begin
                            state_d = S_FETCH;
                            if (col_q == COL_LAST) begin
                                col_d = '0;
                                row_d = row_q + RW'(1);
                            end else begin
                                col_d = col_q + CW'(1);
                            end
                        end
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // abort overrides whatever the state logic decided, including a frame end
        if (abort && state_q != S_IDLE) begin
            state_d      = S_IDLE;
            row_d        = row_q;
            col_d        = col_q;
            timer_d      = '0;
            frame_done_d = 1'b0;
        end

        // outputs are registered from the next state so they line up with it
        rd_en_d   = (state_d == S_FETCH);
        busy_d    = (state_d != S_IDLE);
        drv_set_d = (state_d == S_PULSE) &&  pix_d;
        drv_clr_d = (state_d == S_PULSE) && !pix_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            row_q        <= '0;
            col_q        <= '0;
            timer_q      <= '0;
            pix_q        <= 1'b0;
            rd_en_q      <= 1'b0;
            drv_set_q    <= 1'b0;
            drv_clr_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            timer_q      <= timer_d;
            pix_q        <= pix_d;
            rd_en_q      <= rd_en_d;
            drv_set_q    <= drv_set_d;
            drv_clr_q    <= drv_clr_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign rd_en      = rd_en_q;
    assign rd_row     = row_q;
    assign rd_col     = col_q;
    assign drv_set    = drv_set_q;
    assign drv_clr    = drv_clr_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/flipdot_scan_ctrl.md
# flipdot_scan_ctrl

Frame scan controller for the flipdot panel. On a start pulse it walks every dot in row-major order, fetches the dot's pixel from the frame buffer, and drives the row/column coil drivers with the correct polarity for a timed pulse. It then holds a timed settle gap before moving to the next dot. The block sits between the frame buffer read port and the panel driver board, and its column, row and timer counters are modulo counters gated by a shared timing tick.

## Interface
- COLS, 28, dots per row; column counter wraps at COLS-1
- ROWS, 14, rows per panel; row counter wraps at ROWS-1
- CW, 5, column index width; must satisfy 2^CW ≥ COLS
- RW, 4, row index width; must satisfy 2^RW ≥ ROWS
- TW, 16, timer width
- PULSE_CYC, 1000, coil-on duration in ticks (1 to 2^TW-1)
- GAP_CYC, 200, settle duration in ticks (1 to 2^TW-1)

Ports:
- clk  in  1  system clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- tick  in  1  timing enable; only PULSE/GAP timers advance on it
- start  in  1  frame request; sampled only in IDLE
- abort  in  1  cancel current frame
- rd_en  out  1  frame buffer read strobe
- rd_row  out  RW  row index of current dot
- rd_col  out  CW  column index of current dot
- rd_data  in  1  pixel value; valid the cycle after rd_en
- drv_set  out  1  coil drive, pixel→on polarity
- drv_clr  out  1  coil drive, pixel→off polarity
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse at frame completion

## Operation
- The design is one clock domain and all outputs are registered.
- States are IDLE, FETCH, LATCH, PULSE, GAP.
- IDLE: when start=1, clear row and col to 0 and go to FETCH.
- FETCH: rd_en=1 for exactly one cycle. Go to LATCH.
- LATCH: capture rd_data into pix, clear the timer, go to PULSE.
- PULSE: drv_set=pix and drv_clr=~pix. On tick, the timer increments. When tick=1 and timer==PULSE_CYC-1, clear the timer and go to GAP.
- GAP: both drivers are 0. The timer counts ticks the same way, with exit condition timer==GAP_CYC-1. On exit:
  - If row==ROWS-1 and col==COLS-1, go to IDLE and pulse frame_done.
  - Otherwise advance to the next dot and go to FETCH. col==COLS-1 wraps col to 0 and increments row; otherwise col increments.
- rd_row/rd_col hold the current dot index through FETCH, LATCH, PULSE and GAP.
- drv_set and drv_clr are never both 1.
- abort=1 in any non-IDLE state: go to IDLE on the next edge, drivers 0 from that edge, no frame_done. abort has priority over every other transition.
- start is ignored while busy=1. start and abort asserted together in IDLE: abort wins and the block stays in IDLE.

## Timing
- Reset values: state IDLE, rd_en=0, rd_row=0, rd_col=0, drv_set=0, drv_clr=0, busy=0, frame_done=0, timer=0, pix=0.
- Deassertion of reset_n takes effect asynchronously. The first state change happens no earlier than the first clk edge after release.
- With tick held at 1, one dot takes 2+PULSE_CYC+GAP_CYC cycles.
- start sampled at edge E: busy=1 and rd_en=1 from E.
- Frame end: frame_done=1 and busy=0 in the same cycle, the first IDLE cycle.
- A new start can be accepted in the frame_done cycle.
- tick low stalls the PULSE/GAP timer. FETCH and LATCH do not wait for tick.
- Reset mid-PULSE: drivers drop to 0 immediately, without waiting for a clock edge.

## Test plan
- Reset: COLS=3, ROWS=2, PULSE_CYC=2, GAP_CYC=1, tick=1; pulse reset_n low mid-frame → all outputs 0 immediately, state IDLE.
- Full frame, same parameters, frame buffer all 1s:
  - start at cycle 0 → rd_en high at cycles 1, 6, 11, 16, 21, 26.
  - drv_set high 2 cycles per dot.
  - (row,col) sequence (0,0),(0,1),(0,2),(1,0),(1,1),(1,2).
  - frame_done high only in cycle 31.
- Polarity: pixel pattern 1,0,1,0,1,0 → drv_set/drv_clr alternate per dot, never both high, both 0 during every GAP.
- Tick stall: tick=1 every 4th cycle, PULSE_CYC=2 → PULSE lasts between 5 and 8 cycles (exactly 8 when each PULSE timer run starts just after a tick); FETCH/LATCH still 1 cycle each.
- Abort in PULSE of dot (1,0) → drivers 0 next cycle, busy 0, no frame_done. A later start restarts at (0,0).
- start asserted while busy is ignored, frame completes normally. start in the frame_done cycle → rd_en high in the next cycle.
